// File: rtl/rgb565_pack_defs.sv
// rtl/rgb565_pack_defs.sv - shared FIFO entry layout, Bayer table and dither helpers
package rgb565_pack_defs;

  localparam int ENTRY_W = 18;

  // RGB565 data is {R[7:3] at 15:11, G[7:2] at 10:5, B[7:3] at 4:0}
  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] data;
  } fifo_entry_t;

  function automatic logic [1:0] bayer_idx(input logic y0, input logic x0);
    case ({y0, x0})
      2'b00:   return 2'd0;
      2'b01:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [2:0] a);
    logic [8:0] s;
    s = {1'b0, v} + {6'b0, a};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/rgb565_pix_fifo.sv
// rtl/rgb565_pix_fifo.sv - synchronous show-ahead FIFO with registered fill level
module rgb565_pix_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push;
  logic             pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign pop     = rd_en && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle
  assign push    = wr_en && (!full || pop);
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/rgb565_pixel_packer.sv
// rtl/rgb565_pixel_packer.sv - merges R/G/B channels into tagged RGB565 pixels and queues them
// Optional 2x2 ordered dither (one extra pipeline stage): define RGB565_PACK_DITHER_EN.
module rgb565_pixel_packer
  import rgb565_pack_defs::*;
#(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_rst,
  input  logic             r_val,
  input  logic [7:0]       r_data,
  input  logic             g_val,
  input  logic [7:0]       g_data,
  input  logic             b_val,
  input  logic [7:0]       b_data,
  output logic             pix_val,
  output logic [15:0]      pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  input  logic             pix_rdy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             ovf_err,
  output logic             sync_err,
  input  logic             err_clr
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic          r_held, g_held, b_held;
  logic [7:0]    r_hold, g_hold, b_hold;
  logic [7:0]    r_cur, g_cur, b_cur;
  logic          complete;
  logic          rearrive;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          wr_en, rd_en, drop;
  logic          fifo_full, fifo_empty;
  fifo_entry_t   wr_entry, head;

  assign r_cur    = r_val ? r_data : r_hold;
  assign g_cur    = g_val ? g_data : g_hold;
  assign b_cur    = b_val ? b_data : b_hold;
  assign complete = (r_held || r_val) && (g_held || g_val) && (b_held || b_val);
  assign rearrive = !frame_rst && !complete &&
                    ((r_val && r_held) || (g_val && g_held) || (b_val && b_held));

  always_ff @(posedge clk) begin
    if (!reset_n || frame_rst) begin
      r_held <= 1'b0;
      g_held <= 1'b0;
      b_held <= 1'b0;
      r_hold <= '0;
      g_hold <= '0;
      b_hold <= '0;
      x      <= '0;
      y      <= '0;
    end else if (complete) begin
      r_held <= 1'b0;
      g_held <= 1'b0;
      b_held <= 1'b0;
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else begin
      if (r_val) begin r_hold <= r_data; r_held <= 1'b1; end
      if (g_val) begin g_hold <= g_data; g_held <= 1'b1; end
      if (b_val) begin b_hold <= b_data; b_held <= 1'b1; end
    end
  end

`ifdef RGB565_PACK_DITHER_EN
  logic        pk_valid, pk_sof, pk_eol;
  logic [7:0]  pk_r, pk_g, pk_b;
  logic [1:0]  pk_idx;
  logic [7:0]  r_dith, g_dith, b_dith;
  logic        d_valid;
  fifo_entry_t d_entry;
  logic        unused_lsbs;

  always_ff @(posedge clk) begin
    if (!reset_n || frame_rst) begin
      pk_valid <= 1'b0;
      pk_sof   <= 1'b0;
      pk_eol   <= 1'b0;
      pk_r     <= '0;
      pk_g     <= '0;
      pk_b     <= '0;
      pk_idx   <= '0;
    end else begin
      pk_valid <= complete;
      pk_sof   <= (x == '0) && (y == '0);
      pk_eol   <= (x == X_LAST);
      pk_r     <= r_cur;
      pk_g     <= g_cur;
      pk_b     <= b_cur;
      pk_idx   <= bayer_idx(y[0], x[0]);
    end
  end

  // R/B truncate 3 bits so they take twice the Bayer offset that G (2 bits) takes
  assign r_dith      = sat_add(pk_r, {pk_idx, 1'b0});
  assign g_dith      = sat_add(pk_g, {1'b0, pk_idx});
  assign b_dith      = sat_add(pk_b, {pk_idx, 1'b0});
  assign unused_lsbs = ^{r_dith[2:0], g_dith[1:0], b_dith[2:0]};

  always_ff @(posedge clk) begin
    if (!reset_n || frame_rst) begin
      d_valid <= 1'b0;
      d_entry <= '0;
    end else begin
      d_valid      <= pk_valid;
      d_entry.sof  <= pk_sof;
      d_entry.eol  <= pk_eol;
      d_entry.data <= {r_dith[7:3], g_dith[7:2], b_dith[7:3]};
    end
  end

  assign wr_en    = d_valid;
  assign wr_entry = d_entry;
`else
  logic        pk_valid;
  fifo_entry_t pk_entry;
  logic        unused_lsbs;

  assign unused_lsbs = ^{r_cur[2:0], g_cur[1:0], b_cur[2:0]};

  always_ff @(posedge clk) begin
    if (!reset_n || frame_rst) begin
      pk_valid <= 1'b0;
      pk_entry <= '0;
    end else begin
      pk_valid      <= complete;
      pk_entry.sof  <= (x == '0) && (y == '0);
      pk_entry.eol  <= (x == X_LAST);
      pk_entry.data <= {r_cur[7:3], g_cur[7:2], b_cur[7:3]};
    end
  end

  assign wr_en    = pk_valid;
  assign wr_entry = pk_entry;
`endif

  rgb565_pix_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  assign pix_val  = !fifo_empty;
  assign rd_en    = pix_val && pix_rdy;
  assign drop     = wr_en && fifo_full && !rd_en;
  assign pix_data = pix_val ? head.data : '0;
  assign pix_sof  = pix_val && head.sof;
  assign pix_eol  = pix_val && head.eol;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_err  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      ovf_err  <= (ovf_err && !err_clr) || drop;
      sync_err <= (sync_err && !err_clr) || rearrive;
    end
  end

endmodule
